// File: rtl/gray_tracker.sv
// Gray-coded position tracker: decodes each sample, accepts only +/-1 steps from the
// last good position, and keeps sticky wrap and error flags plus a saturating step count.
module gray_tracker #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] GrayIn,
  output logic [WIDTH-1:0] Binary,
  output logic             Locked,
  output logic             Dir,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Error,
  output logic [CNT_W-1:0] StepCount
);

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_FAULT} state_t;

  state_t           state_q = S_INIT;
  state_t           state_d;
  logic [WIDTH-1:0] bin_q = '0;
  logic [WIDTH-1:0] bin_d;
  logic             locked_q = 1'b0;
  logic             locked_d;
  logic             dir_q = 1'b0;
  logic             dir_d;
  logic             ovf_q = 1'b0;
  logic             ovf_d;
  logic             unf_q = 1'b0;
  logic             unf_d;
  logic             err_q = 1'b0;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q = '0;
  logic [CNT_W-1:0] cnt_d;

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] bin_dec;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign dec     = gray2bin(GrayIn);
  assign bin_inc = bin_q + WIDTH'(1);
  assign bin_dec = bin_q - WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    locked_d = locked_q;
    dir_d    = dir_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (Valid) begin
      case (state_q)
        S_INIT: begin
          bin_d    = dec;
          locked_d = 1'b1;
          state_d  = S_TRACK;
        end
        S_TRACK: begin
          // Legality is judged on the binary difference; a single Gray bit flip
          // between non-adjacent positions still lands in the error branch.
          if (dec == bin_inc) begin
            bin_d = dec;
            dir_d = 1'b1;
            cnt_d = sat_inc(cnt_q);
            if (bin_q == '1) ovf_d = 1'b1;
          end else if (dec == bin_dec) begin
            bin_d = dec;
            dir_d = 1'b0;
            cnt_d = sat_inc(cnt_q);
            if (bin_q == '0) unf_d = 1'b1;
          end else if (dec != bin_q) begin
            err_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_INIT;
      bin_q    <= '0;
      locked_q <= 1'b0;
      dir_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Binary    = bin_q;
  assign Locked    = locked_q;
  assign Dir       = dir_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Error     = err_q;
  assign StepCount = cnt_q;

endmodule

// File: tb/tb_gray_tracker.sv
// Bench for gray_tracker: directed Gray sample sequences, a positional reference model
// compared every cycle, and literal checkpoints after each scenario.
module tb_gray_tracker;
  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
  localparam int MODN  = 1 << WIDTH;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Valid = 1'b0;
  logic [WIDTH-1:0] GrayIn = '0;
  logic [WIDTH-1:0] Binary;
  logic             Locked, Dir, Overflow, Underflow, Error;
  logic [CNT_W-1:0] StepCount;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  gray_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn),
    .Binary(Binary), .Locked(Locked), .Dir(Dir), .Overflow(Overflow),
    .Underflow(Underflow), .Error(Error), .StepCount(StepCount)
  );

  always #5 Clk = ~Clk;

  // Reference model: position as an integer, the Gray code inverted by search.
  int m_pos = 0, m_cnt = 0;
  bit m_locked = 0, m_dir = 0, m_ovf = 0, m_unf = 0, m_err = 0;

  function automatic int gray_value(input int g);
    for (int i = 0; i < MODN; i++) begin
      if ((i ^ (i >> 1)) == g) return i;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    int d, diff;
    if (Reset) begin
      m_pos <= 0; m_cnt <= 0; m_locked <= 0; m_dir <= 0;
      m_ovf <= 0; m_unf <= 0; m_err <= 0;
    end else if (Valid && !m_err) begin
      d = gray_value(int'(GrayIn));
      if (!m_locked) begin
        m_pos <= d;
        m_locked <= 1;
      end else begin
        diff = (d - m_pos + MODN) % MODN;
        if (diff == 1) begin
          m_pos <= d; m_dir <= 1;
          m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
          if (m_pos == MODN - 1) m_ovf <= 1;
        end else if (diff == MODN - 1) begin
          m_pos <= d; m_dir <= 0;
          m_cnt <= (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
          if (m_pos == 0) m_unf <= 1;
        end else if (diff != 0) begin
          m_err <= 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_binary", int'(Binary), m_pos);
      chk("model_locked", int'(Locked), int'(m_locked));
      chk("model_dir", int'(Dir), int'(m_dir));
      chk("model_overflow", int'(Overflow), int'(m_ovf));
      chk("model_underflow", int'(Underflow), int'(m_unf));
      chk("model_error", int'(Error), int'(m_err));
      chk("model_stepcount", int'(StepCount), m_cnt);
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] g);
    @(negedge Clk);
    Valid  = v;
    GrayIn = g;
  endtask

  task automatic idle();
    @(negedge Clk);
    Valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic lit(input string tag, input int b, input int lk, input int dr,
                     input int ov, input int un, input int er, input int cn);
    chk({tag, "_binary"}, int'(Binary), b);
    chk({tag, "_locked"}, int'(Locked), lk);
    chk({tag, "_dir"}, int'(Dir), dr);
    chk({tag, "_overflow"}, int'(Overflow), ov);
    chk({tag, "_underflow"}, int'(Underflow), un);
    chk({tag, "_error"}, int'(Error), er);
    chk({tag, "_stepcount"}, int'(StepCount), cn);
  endtask

  logic [WIDTH-1:0] seq1 [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                                 3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    do_reset();
    chk_en = 1'b1;
    lit("reset", 0, 0, 0, 0, 0, 0, 0);

    // Full up count with wrap 7 -> 0
    for (int i = 0; i < 9; i++) step(1'b1, seq1[i]);
    idle();
    lit("t1_wrap_up", 0, 1, 1, 1, 0, 0, 8);

    // Down wrap 0 -> 7, then up wrap back: both sticky flags set
    do_reset();
    step(1'b1, 3'b000);
    step(1'b1, 3'b100);
    idle();
    lit("t2_wrap_down", 7, 1, 0, 0, 1, 0, 1);
    step(1'b1, 3'b000);
    idle();
    lit("t2_both_flags", 0, 1, 1, 1, 1, 0, 2);

    // Illegal jump 1 -> 6 freezes tracker
    do_reset();
    step(1'b1, 3'b001);
    step(1'b1, 3'b101);
    idle();
    lit("t3_error", 1, 1, 0, 0, 0, 1, 0);
    step(1'b1, 3'b011);
    step(1'b1, 3'b000);
    idle();
    lit("t3_frozen", 1, 1, 0, 0, 0, 1, 0);

    // One-bit Gray change between non-adjacent positions (3 -> 4 ok, 0 -> 7 ok, 1 -> 6 bad) -- 2 -> 13? use 010 -> 000: bin 3 -> 0
    do_reset();
    step(1'b1, 3'b010);
    step(1'b1, 3'b000);
    idle();
    lit("t3_hamming1", 3, 1, 0, 0, 0, 1, 0);

    // Idle cycles and repeats interleaved with real steps
    do_reset();
    step(1'b1, 3'b000);
    idle();
    step(1'b1, 3'b000);
    step(1'b1, 3'b001);
    idle();
    idle();
    step(1'b1, 3'b001);
    step(1'b1, 3'b011);
    step(1'b1, 3'b011);
    idle();
    idle();
    lit("t4_repeats", 2, 1, 1, 0, 0, 0, 2);

    // Reset together with Valid mid-stream
    do_reset();
    step(1'b1, 3'b000);
    step(1'b1, 3'b001);
    step(1'b1, 3'b011);
    @(negedge Clk);
    Reset  = 1'b1;
    Valid  = 1'b1;
    GrayIn = 3'b010;
    @(negedge Clk);
    Reset = 1'b0;
    Valid = 1'b0;
    lit("t5_reset_valid", 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 3'b110);
    idle();
    lit("t5_fresh", 4, 1, 0, 0, 0, 0, 0);

    // Saturation of the step counter
    do_reset();
    step(1'b1, 3'b000);
    for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 3'b001 : 3'b000);
    idle();
    lit("t6_saturate", 0, 1, 0, 0, 0, 0, 255);

    idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
